// File: rtl/l1_req_ctrl_fsm.sv
// L1 upstream-request controller: request FIFO plus a lookup/snoop/update/response FSM.
// Optional WAIT-state timeout is compiled in with `define L1_REQ_TIMEOUT_EN.
module l1_req_ctrl_fsm #(
  parameter int ADDR_W      = 32,
  parameter int REQ_DEPTH   = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cdreq_valid,
  output logic              cdreq_ready,
  input  logic [2:0]        cdreq_op,
  input  logic [ADDR_W-1:0] cdreq_addr,
  output logic [ADDR_W-1:0] lkup_addr,
  input  logic              lkup_hit,
  input  logic [2:0]        blk_curSt,
  output logic              sdreq_valid,
  input  logic              sdreq_ready,
  output logic [2:0]        sdreq_op,
  output logic [ADDR_W-1:0] sdreq_addr,
  input  logic              sursp_valid,
  input  logic [2:0]        sursp_rsp,
  output logic              blk_we,
  output logic [2:0]        blk_nxtSt,
  output logic              cursp_valid,
  input  logic              cursp_ready,
  output logic [1:0]        cursp_rsp,
  output logic              busy
);

  localparam logic [2:0] CDREQ_RD  = 3'd0;
  localparam logic [2:0] CDREQ_RFO = 3'd1;
  localparam logic [2:0] CDREQ_MD  = 3'd2;
  localparam logic [2:0] CDREQ_WB  = 3'd3;

  localparam logic [2:0] SDREQ_RD  = 3'd0;
  localparam logic [2:0] SDREQ_RFO = 3'd1;
  localparam logic [2:0] SDREQ_INV = 3'd2;

  localparam logic [2:0] SURSP_SNOOP = 3'd1;
  localparam logic [2:0] SURSP_FETCH = 3'd2;

  localparam logic [1:0] CURSP_OKAY = 2'b00;
  localparam logic [1:0] CURSP_ERR  = 2'b01;

  localparam logic [2:0] ST_INVALID   = 3'd0;
  localparam logic [2:0] ST_SHARED    = 3'd1;
  localparam logic [2:0] ST_EXCLUSIVE = 3'd2;
  localparam logic [2:0] ST_MODIFIED  = 3'd3;
  localparam logic [2:0] ST_MIGRATED  = 3'd4;

  localparam int PW = $clog2(REQ_DEPTH);

  if (REQ_DEPTH < 2 || (REQ_DEPTH & (REQ_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("REQ_DEPTH must be a power of two and at least 2");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_SNOOP,
    S_WAIT,
    S_UPDATE,
    S_RESP
  } state_t;

  state_t            state;
  logic [2:0]        op_q;
  logic [ADDR_W-1:0] fifo_addr [REQ_DEPTH];
  logic [2:0]        fifo_op   [REQ_DEPTH];
  logic [PW:0]       wr_ptr;
  logic [PW:0]       rd_ptr;
  logic              empty;
  logic              full;
  logic              push;
  logic              pop;
  logic              is_wr;
  logic [2:0]        wr_nxt;

`ifdef L1_REQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] wait_cnt;
`endif

  // Extra wrap bit distinguishes full from empty when the index bits match.
  assign empty       = (wr_ptr == rd_ptr);
  assign full        = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign push        = cdreq_valid && !full;
  assign pop         = (state == S_IDLE) && !empty;
  assign cdreq_ready = !full;
  assign busy        = (state != S_IDLE) || !empty;

  assign is_wr  = (op_q == CDREQ_RFO) || (op_q == CDREQ_MD) || (op_q == CDREQ_WB);
  assign wr_nxt = (op_q == CDREQ_WB) ? ST_MODIFIED : ST_MIGRATED;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr[PW-1:0]] <= cdreq_addr;
      fifo_op[wr_ptr[PW-1:0]]   <= cdreq_op;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      op_q        <= CDREQ_RD;
      lkup_addr   <= '0;
      sdreq_valid <= 1'b0;
      sdreq_op    <= SDREQ_RD;
      sdreq_addr  <= '0;
      blk_we      <= 1'b0;
      blk_nxtSt   <= ST_INVALID;
      cursp_valid <= 1'b0;
      cursp_rsp   <= CURSP_OKAY;
`ifdef L1_REQ_TIMEOUT_EN
      wait_cnt    <= '0;
`endif
    end else begin
      blk_we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!empty) begin
            op_q      <= fifo_op[rd_ptr[PW-1:0]];
            lkup_addr <= fifo_addr[rd_ptr[PW-1:0]];
            state     <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (op_q == CDREQ_RD) begin
            if (lkup_hit) begin
              cursp_valid <= 1'b1;
              cursp_rsp   <= CURSP_OKAY;
              state       <= S_RESP;
            end else begin
              sdreq_valid <= 1'b1;
              sdreq_op    <= SDREQ_RD;
              sdreq_addr  <= lkup_addr;
              state       <= S_SNOOP;
            end
          end else if (is_wr) begin
            if (lkup_hit && blk_curSt == ST_SHARED) begin
              sdreq_valid <= 1'b1;
              sdreq_op    <= SDREQ_INV;
              sdreq_addr  <= lkup_addr;
              state       <= S_SNOOP;
            end else if (lkup_hit) begin
              blk_we    <= 1'b1;
              blk_nxtSt <= wr_nxt;
              state     <= S_UPDATE;
            end else begin
              sdreq_valid <= 1'b1;
              sdreq_op    <= SDREQ_RFO;
              sdreq_addr  <= lkup_addr;
              state       <= S_SNOOP;
            end
          end else begin
            // Undefined opcode: refuse it rather than touch the tag state.
            cursp_valid <= 1'b1;
            cursp_rsp   <= CURSP_ERR;
            state       <= S_RESP;
          end
        end
        S_SNOOP: begin
          if (sdreq_ready) begin
            sdreq_valid <= 1'b0;
            state       <= S_WAIT;
`ifdef L1_REQ_TIMEOUT_EN
            wait_cnt    <= '0;
`endif
          end
        end
        S_WAIT: begin
          if (sursp_valid) begin
            if (op_q == CDREQ_RD) begin
              if (sursp_rsp == SURSP_SNOOP) begin
                blk_we    <= 1'b1;
                blk_nxtSt <= ST_SHARED;
                state     <= S_UPDATE;
              end else if (sursp_rsp == SURSP_FETCH) begin
                blk_we    <= 1'b1;
                blk_nxtSt <= ST_EXCLUSIVE;
                state     <= S_UPDATE;
              end else begin
                cursp_valid <= 1'b1;
                cursp_rsp   <= CURSP_ERR;
                state       <= S_RESP;
              end
            end else begin
              blk_we    <= 1'b1;
              blk_nxtSt <= wr_nxt;
              state     <= S_UPDATE;
            end
          end
`ifdef L1_REQ_TIMEOUT_EN
          else if (wait_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            cursp_valid <= 1'b1;
            cursp_rsp   <= CURSP_ERR;
            state       <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        S_UPDATE: begin
          cursp_valid <= 1'b1;
          cursp_rsp   <= CURSP_OKAY;
          state       <= S_RESP;
        end
        S_RESP: begin
          if (cursp_ready) begin
            cursp_valid <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l1_req_ctrl_fsm.sv
// Self-checking bench for l1_req_ctrl_fsm: scoreboard of expected snoops, tag writes and responses.
// Build with +define+L1_REQ_TIMEOUT_EN to exercise the WAIT timeout (TIMEOUT_CYC=8).
module tb_l1_req_ctrl_fsm;

  localparam int AW = 32;

  localparam logic [2:0] CDREQ_RD  = 3'd0;
  localparam logic [2:0] CDREQ_RFO = 3'd1;
  localparam logic [2:0] CDREQ_MD  = 3'd2;
  localparam logic [2:0] CDREQ_WB  = 3'd3;
  localparam logic [2:0] SDREQ_RD  = 3'd0;
  localparam logic [2:0] SDREQ_RFO = 3'd1;
  localparam logic [2:0] SDREQ_INV = 3'd2;
  localparam logic [2:0] SURSP_SNOOP = 3'd1;
  localparam logic [2:0] SURSP_FETCH = 3'd2;
  localparam logic [2:0] SURSP_OTHER = 3'd7;
  localparam logic [1:0] CURSP_OKAY = 2'b00;
  localparam logic [1:0] CURSP_ERR  = 2'b01;
  localparam logic [2:0] ST_INVALID   = 3'd0;
  localparam logic [2:0] ST_SHARED    = 3'd1;
  localparam logic [2:0] ST_EXCLUSIVE = 3'd2;
  localparam logic [2:0] ST_MODIFIED  = 3'd3;
  localparam logic [2:0] ST_MIGRATED  = 3'd4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cdreq_valid = 1'b0;
  logic          cdreq_ready;
  logic [2:0]    cdreq_op = 3'd0;
  logic [AW-1:0] cdreq_addr = '0;
  logic [AW-1:0] lkup_addr;
  logic          lkup_hit = 1'b0;
  logic [2:0]    blk_curSt = 3'd0;
  logic          sdreq_valid;
  logic          sdreq_ready = 1'b1;
  logic [2:0]    sdreq_op;
  logic [AW-1:0] sdreq_addr;
  logic          sursp_valid = 1'b0;
  logic [2:0]    sursp_rsp = 3'd0;
  logic          blk_we;
  logic [2:0]    blk_nxtSt;
  logic          cursp_valid;
  logic          cursp_ready = 1'b1;
  logic [1:0]    cursp_rsp;
  logic          busy;

  always #5 clk = ~clk;

  l1_req_ctrl_fsm #(.ADDR_W(AW), .REQ_DEPTH(4), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cdreq_valid(cdreq_valid), .cdreq_ready(cdreq_ready), .cdreq_op(cdreq_op), .cdreq_addr(cdreq_addr),
    .lkup_addr(lkup_addr), .lkup_hit(lkup_hit), .blk_curSt(blk_curSt),
    .sdreq_valid(sdreq_valid), .sdreq_ready(sdreq_ready), .sdreq_op(sdreq_op), .sdreq_addr(sdreq_addr),
    .sursp_valid(sursp_valid), .sursp_rsp(sursp_rsp),
    .blk_we(blk_we), .blk_nxtSt(blk_nxtSt),
    .cursp_valid(cursp_valid), .cursp_ready(cursp_ready), .cursp_rsp(cursp_rsp),
    .busy(busy)
  );

  typedef struct packed {
    logic [2:0]    v;
    logic [AW-1:0] addr;
  } exp_t;

  exp_t q_sd[$];
  exp_t q_wr[$];
  exp_t q_rsp[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail = 0;
  logic       rsp_en = 1'b0;
  logic [2:0] rsp_code = SURSP_FETCH;
  logic [76:0] rst_got;
  logic [76:0] rst_exp;

  // Scoreboard: every snoop handshake, tag write and response handshake pops its expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (sdreq_valid && sdreq_ready) begin
        n_checks++;
        if (q_sd.size() == 0) begin
          n_fail++;
          $display("FAIL sdreq_unexpected: op=%0d addr=%h, required no snoop", sdreq_op, sdreq_addr);
        end else begin
          mon_e = q_sd.pop_front();
          if (sdreq_op !== mon_e.v || sdreq_addr !== mon_e.addr) begin
            n_fail++;
            $display("FAIL sdreq_payload: op=%0d addr=%h, required op=%0d addr=%h",
                     sdreq_op, sdreq_addr, mon_e.v, mon_e.addr);
          end
        end
      end
      if (blk_we) begin
        n_checks++;
        if (q_wr.size() == 0) begin
          n_fail++;
          $display("FAIL blk_we_unexpected: nxt=%0d addr=%h, required no write", blk_nxtSt, lkup_addr);
        end else begin
          mon_e = q_wr.pop_front();
          if (blk_nxtSt !== mon_e.v || lkup_addr !== mon_e.addr) begin
            n_fail++;
            $display("FAIL blk_write: nxt=%0d addr=%h, required nxt=%0d addr=%h",
                     blk_nxtSt, lkup_addr, mon_e.v, mon_e.addr);
          end
        end
      end
      if (cursp_valid && cursp_ready) begin
        n_checks++;
        if (q_rsp.size() == 0) begin
          n_fail++;
          $display("FAIL cursp_unexpected: rsp=%0d addr=%h, required no response", cursp_rsp, lkup_addr);
        end else begin
          mon_e = q_rsp.pop_front();
          if (cursp_rsp !== mon_e.v[1:0] || lkup_addr !== mon_e.addr) begin
            n_fail++;
            $display("FAIL cursp_payload: rsp=%0d addr=%h, required rsp=%0d addr=%h",
                     cursp_rsp, lkup_addr, mon_e.v[1:0], mon_e.addr);
          end
        end
      end
    end
  end

  // Downstream model: answer each accepted snoop in the first WAIT cycle.
  always begin
    @(negedge clk);
    if (rsp_en && rst_n && sdreq_valid && sdreq_ready) begin
      @(posedge clk);
      #2;
      sursp_rsp   = rsp_code;
      sursp_valid = 1'b1;
      @(posedge clk);
      #2;
      sursp_valid = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, required completion of all tests");
    $fatal(1, "watchdog");
  end

  task automatic send_req(input logic [2:0] op, input logic [AW-1:0] addr);
    int k = 0;
    cdreq_op    = op;
    cdreq_addr  = addr;
    cdreq_valid = 1'b1;
    while (!cdreq_ready && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    @(posedge clk); #1;
    cdreq_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while ((busy || q_sd.size() != 0 || q_wr.size() != 0 || q_rsp.size() != 0) && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    n_checks++;
    if (busy || q_sd.size() != 0 || q_wr.size() != 0 || q_rsp.size() != 0) begin
      n_fail++;
      $display("FAIL idle_drain: busy=%0b pending sd=%0d wr=%0d rsp=%0d, required idle with nothing pending",
               busy, q_sd.size(), q_wr.size(), q_rsp.size());
    end
    q_sd.delete(); q_wr.delete(); q_rsp.delete();
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_exp = {3'b000, ST_INVALID, CURSP_OKAY, SDREQ_RD, 32'h0, 32'h0, 1'b0, 1'b1};
    rst_got = {sdreq_valid, blk_we, cursp_valid, blk_nxtSt, cursp_rsp, sdreq_op,
               lkup_addr, sdreq_addr, busy, cdreq_ready};
    n_checks++;
    if (rst_got !== rst_exp) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, required %h", rst_got, rst_exp);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_rd_hit;
    logic [2:0] seen = '0;
    lkup_hit = 1'b1; blk_curSt = ST_EXCLUSIVE; cursp_ready = 1'b1; rsp_en = 1'b0;
    q_rsp.push_back({1'b0, CURSP_OKAY, 32'h40});
    send_req(CDREQ_RD, 32'h40);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      seen[i] = cursp_valid;
    end
    n_checks++;
    if (seen !== 3'b100) begin
      n_fail++;
      $display("FAIL rd_hit_latency: cursp_valid over t..t+2=%b, required 100", seen);
    end
    @(posedge clk); #1;
    wait_idle(20);
  endtask

  task automatic test_rd_miss(input logic [2:0] code, input logic [2:0] nxt, input logic [AW-1:0] addr);
    int k = 0;
    lkup_hit = 1'b0; blk_curSt = ST_INVALID; sdreq_ready = 1'b1; cursp_ready = 1'b1;
    rsp_en = 1'b1; rsp_code = code;
    q_sd.push_back({SDREQ_RD, addr});
    q_wr.push_back({nxt, addr});
    q_rsp.push_back({1'b0, CURSP_OKAY, addr});
    send_req(CDREQ_RD, addr);
    do begin
      @(negedge clk);
      k++;
    end while (!sursp_valid && k < 40);
    @(negedge clk);
    n_checks++;
    if (blk_we !== 1'b1 || cursp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL miss_update_cycle: blk_we=%0b cursp_valid=%0b, required 1 and 0", blk_we, cursp_valid);
    end
    @(negedge clk);
    n_checks++;
    if (cursp_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL miss_latency: cursp_valid=%0b two cycles after sursp, required 1", cursp_valid);
    end
    @(posedge clk); #1;
    wait_idle(30);
  endtask

  task automatic test_rd_err;
    lkup_hit = 1'b0; sdreq_ready = 1'b1; cursp_ready = 1'b1;
    rsp_en = 1'b1; rsp_code = SURSP_OTHER;
    q_sd.push_back({SDREQ_RD, 32'h1000});
    q_rsp.push_back({1'b0, CURSP_ERR, 32'h1000});
    send_req(CDREQ_RD, 32'h1000);
    wait_idle(40);
  endtask

  task automatic test_write_hits;
    logic [3:0] we_seen = '0;
    logic [3:0] rv_seen = '0;
    sdreq_ready = 1'b1; cursp_ready = 1'b1; rsp_en = 1'b1; rsp_code = SURSP_OTHER;
    // RFO on a SHARED line needs an invalidate first.
    lkup_hit = 1'b1; blk_curSt = ST_SHARED;
    q_sd.push_back({SDREQ_INV, 32'h100});
    q_wr.push_back({ST_MIGRATED, 32'h100});
    q_rsp.push_back({1'b0, CURSP_OKAY, 32'h100});
    send_req(CDREQ_RFO, 32'h100);
    wait_idle(40);
    // WB on EXCLUSIVE updates locally.
    blk_curSt = ST_EXCLUSIVE;
    q_wr.push_back({ST_MODIFIED, 32'h140});
    q_rsp.push_back({1'b0, CURSP_OKAY, 32'h140});
    send_req(CDREQ_WB, 32'h140);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      we_seen[i] = blk_we;
      rv_seen[i] = cursp_valid;
    end
    n_checks++;
    if (we_seen !== 4'b0100 || rv_seen !== 4'b1000) begin
      n_fail++;
      $display("FAIL wr_hit_latency: blk_we t..t+3=%b cursp_valid=%b, required 0100 and 1000",
               {we_seen[0], we_seen[1], we_seen[2], we_seen[3]},
               {rv_seen[0], rv_seen[1], rv_seen[2], rv_seen[3]});
    end
    @(posedge clk); #1;
    wait_idle(20);
    blk_curSt = ST_MODIFIED;
    q_wr.push_back({ST_MIGRATED, 32'h180});
    q_rsp.push_back({1'b0, CURSP_OKAY, 32'h180});
    send_req(CDREQ_MD, 32'h180);
    wait_idle(20);
    lkup_hit = 1'b0; rsp_code = SURSP_SNOOP;
    q_sd.push_back({SDREQ_RFO, 32'h1C0});
    q_wr.push_back({ST_MIGRATED, 32'h1C0});
    q_rsp.push_back({1'b0, CURSP_OKAY, 32'h1C0});
    send_req(CDREQ_RFO, 32'h1C0);
    wait_idle(40);
  endtask

  task automatic test_back_to_back;
    logic [AW-1:0] a;
    lkup_hit = 1'b0; sdreq_ready = 1'b0; cursp_ready = 1'b1; rsp_en = 1'b1; rsp_code = SURSP_FETCH;
    cdreq_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a = 32'h200 + 32'(i) * 32'h40;
      cdreq_op = CDREQ_RD; cdreq_addr = a;
      q_sd.push_back({SDREQ_RD, a});
      q_wr.push_back({ST_EXCLUSIVE, a});
      q_rsp.push_back({1'b0, CURSP_OKAY, a});
      @(negedge clk);
      n_checks++;
      if (cdreq_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_accept: request %0d cdreq_ready=%0b, required 1", i, cdreq_ready);
      end
      @(posedge clk); #1;
    end
    cdreq_valid = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if (cdreq_ready !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_full: cdreq_ready=%0b busy=%0b, required 0 and 1", cdreq_ready, busy);
    end
    @(posedge clk); #1;
    sdreq_ready = 1'b1;
    wait_idle(300);
    n_checks++;
    if (cdreq_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_drained: cdreq_ready=%0b, required 1", cdreq_ready);
    end
  endtask

  task automatic test_stall;
    int k = 0;
    int bad_sd = 0;
    int bad_rsp = 0;
    lkup_hit = 1'b0; sdreq_ready = 1'b0; cursp_ready = 1'b0; rsp_en = 1'b1; rsp_code = SURSP_SNOOP;
    q_sd.push_back({SDREQ_RD, 32'h300});
    q_wr.push_back({ST_SHARED, 32'h300});
    q_rsp.push_back({1'b0, CURSP_OKAY, 32'h300});
    send_req(CDREQ_RD, 32'h300);
    do begin
      @(negedge clk);
      k++;
    end while (!sdreq_valid && k < 20);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (sdreq_valid !== 1'b1 || sdreq_op !== SDREQ_RD || sdreq_addr !== 32'h300) bad_sd++;
      if (i == 3) begin
        sursp_rsp = SURSP_FETCH;
        sursp_valid = 1'b1;
      end
      if (i == 4) sursp_valid = 1'b0;
    end
    n_checks++;
    if (bad_sd != 0) begin
      n_fail++;
      $display("FAIL sdreq_hold: %0d of 10 stalled cycles lost valid/op/addr, required 0", bad_sd);
    end
    @(posedge clk); #1;
    sdreq_ready = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!cursp_valid && k < 30);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (cursp_valid !== 1'b1 || cursp_rsp !== CURSP_OKAY || lkup_addr !== 32'h300) bad_rsp++;
    end
    n_checks++;
    if (bad_rsp != 0) begin
      n_fail++;
      $display("FAIL cursp_hold: %0d of 5 stalled cycles lost valid/rsp/addr, required 0", bad_rsp);
    end
    @(posedge clk); #1;
    cursp_ready = 1'b1;
    wait_idle(20);
  endtask

  task automatic test_wait;
    int k = 0;
    int early = 0;
    lkup_hit = 1'b0; sdreq_ready = 1'b1; cursp_ready = 1'b1; rsp_en = 1'b0;
    q_sd.push_back({SDREQ_RD, 32'h380});
`ifdef L1_REQ_TIMEOUT_EN
    q_rsp.push_back({1'b0, CURSP_ERR, 32'h380});
`else
    q_wr.push_back({ST_EXCLUSIVE, 32'h380});
    q_rsp.push_back({1'b0, CURSP_OKAY, 32'h380});
`endif
    send_req(CDREQ_RD, 32'h380);
    do begin
      @(negedge clk);
      k++;
    end while (!(sdreq_valid && sdreq_ready) && k < 20);
`ifdef L1_REQ_TIMEOUT_EN
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (cursp_valid !== 1'b0 || busy !== 1'b1) early++;
    end
    @(negedge clk);
    n_checks++;
    if (early != 0 || cursp_valid !== 1'b1 || cursp_rsp !== CURSP_ERR) begin
      n_fail++;
      $display("FAIL wait_timeout: early=%0d cursp_valid=%0b rsp=%0d after 8 WAIT cycles, required 0,1,%0d",
               early, cursp_valid, cursp_rsp, CURSP_ERR);
    end
`else
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (cursp_valid !== 1'b0 || busy !== 1'b1) early++;
    end
    n_checks++;
    if (early != 0) begin
      n_fail++;
      $display("FAIL wait_hold: left WAIT in %0d of 30 cycles without sursp, required 0", early);
    end
    sursp_rsp = SURSP_FETCH;
    sursp_valid = 1'b1;
    @(negedge clk);
    sursp_valid = 1'b0;
`endif
    @(posedge clk); #1;
    wait_idle(20);
  endtask

  task automatic test_reset_mid;
    int bad = 0;
    lkup_hit = 1'b0; sdreq_ready = 1'b1; cursp_ready = 1'b1; rsp_en = 1'b0;
    q_sd.push_back({SDREQ_RD, 32'h3C0});
    send_req(CDREQ_RD, 32'h3C0);
    send_req(CDREQ_RD, 32'h400);
    send_req(CDREQ_RD, 32'h440);
    repeat (4) begin
      @(posedge clk); #1;
    end
    n_checks++;
    if (q_sd.size() != 0 || busy !== 1'b1 || sdreq_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_setup: pending_sd=%0d busy=%0b sdreq_valid=%0b, required 0,1,0",
               q_sd.size(), busy, sdreq_valid);
    end
    rst_n = 1'b0;
    #1;
    rst_got = {sdreq_valid, blk_we, cursp_valid, blk_nxtSt, cursp_rsp, sdreq_op,
               lkup_addr, sdreq_addr, busy, cdreq_ready};
    n_checks++;
    if (rst_got !== rst_exp) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got %h, required %h", rst_got, rst_exp);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    q_sd.delete(); q_wr.delete(); q_rsp.delete();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || sdreq_valid !== 1'b0 || cursp_valid !== 1'b0 || cdreq_ready !== 1'b1) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL reset_mid_flush: activity in %0d of 10 cycles after release, required 0", bad);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset;
    test_rd_hit;
    test_rd_miss(SURSP_FETCH, ST_EXCLUSIVE, 32'h80);
    test_rd_miss(SURSP_SNOOP, ST_SHARED, 32'h80);
    test_rd_err;
    test_write_hits;
    test_back_to_back;
    test_stall;
    test_wait;
    test_reset_mid;
    test_rd_hit;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
